// File: rtl/twos_to_signmag_serial.sv
// twos_to_signmag_serial: bit-serial two's complement to sign-magnitude decoder.
// Negative operands are negated LSB first (copy up to the first 1, invert after); others bypass.
module twos_to_signmag_serial #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in_data,
    output logic             busy,
    output logic             done,
    output logic             sign,
    output logic [WIDTH-1:0] mag,
    output logic             min_neg
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [WIDTH-1:0] MIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] r_res;
    logic [CNT_W-1:0] r_cnt;
    logic             r_seen;
    logic             r_busy;
    logic             r_done;
    logic             r_sign;
    logic [WIDTH-1:0] r_mag;
    logic             r_min_neg;
    logic             w_out_bit;
    logic [WIDTH-1:0] w_res;

    assign w_out_bit = r_seen ? ~r_shreg[0] : r_shreg[0];
    assign w_res     = {w_out_bit, r_res[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_res     <= '0;
            r_cnt     <= '0;
            r_seen    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sign    <= 1'b0;
            r_mag     <= '0;
            r_min_neg <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                RUN: begin
                    r_res   <= w_res;
                    r_shreg <= r_shreg >> 1;
                    r_seen  <= r_seen | r_shreg[0];
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH-1)) begin
                        r_state   <= DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_sign    <= 1'b1;
                        r_mag     <= w_res;
                        r_min_neg <= (w_res == MIN_MAG);
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request
                    if (!start) begin
                        r_state <= IDLE;
                    end else if (in_data[WIDTH-1]) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                        r_shreg <= in_data;
                        r_res   <= '0;
                        r_seen  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_state   <= DONE;
                        r_done    <= 1'b1;
                        r_sign    <= 1'b0;
                        r_mag     <= in_data;
                        r_min_neg <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign sign    = r_sign;
    assign mag     = r_mag;
    assign min_neg = r_min_neg;
endmodule
